nios_system_irq_aggregator: RTL

NIOS_SYSTEM_IRQ_AGGREGATOR -- requirements
Module: nios_system_irq_aggregator

---
 rtl/nios_system_irq_pkg.sv | 16 +
 rtl/nios_system_irq_sync.sv | 32 +++
 rtl/nios_system_irq_aggregator.sv | 120 ++++++++++++
 3 files changed

// File: rtl/nios_system_irq_pkg.sv
// Shared register map and field positions for the NIOS interrupt aggregator.
package nios_system_irq_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
    localparam logic [2:0] ADDR_HIGHEST  = 3'd4;
    localparam logic [2:0] ADDR_RAW      = 3'd5;

    // HIGHEST register: "any active" flag position; index lives in bits 3:0
    localparam int unsigned HIGHEST_VLD_BIT = 15;

endpackage

// File: rtl/nios_system_irq_sync.sv
// Three-stage synchronizer: s2 is the clean copy of the async input, s3 is s2
// delayed one clock so the caller can detect rising edges.
module nios_system_irq_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] s2_o,
    output logic [WIDTH-1:0] s3_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] s3_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign s2_o = s2_q;
    assign s3_o = s3_q;

endmodule

// File: rtl/nios_system_irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-source level/edge capture, mask, W1C
// pending, lowest-index priority encoder and a registered CPU interrupt.
module nios_system_irq_aggregator
    import nios_system_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               chipselect,
    input  logic [2:0]         address,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq
);

    logic [NUM_SRC-1:0] s2;
    logic [NUM_SRC-1:0] s3;
    logic [NUM_SRC-1:0] rise;

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] edge_sel_q, edge_sel_d;
    logic [NUM_SRC-1:0] edge_arm_q, edge_arm_d;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] active;
    logic [3:0]         high_idx;
    logic [15:0]        readdata_q, readdata_d;
    logic               irq_q, irq_d;
    logic               wr_en;
    logic               unused_wdata_bits;

    nios_system_irq_sync #(.WIDTH(NUM_SRC)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (irq_in),
        .s2_o    (s2),
        .s3_o    (s3)
    );

    assign wr_en             = chipselect & ~write_n;
    assign rise              = s2 & ~s3;
    assign active            = pending_q & mask_q;
    assign unused_wdata_bits = ^writedata;

    always_comb begin
        mask_d     = mask_q;
        edge_sel_d = edge_sel_q;
        w1c        = '0;
        if (wr_en) begin
            case (address)
                ADDR_PENDING:  w1c        = writedata[NUM_SRC-1:0];
                ADDR_MASK:     mask_d     = writedata[NUM_SRC-1:0];
                ADDR_EDGE_SEL: edge_sel_d = writedata[NUM_SRC-1:0];
                default:       ;
            endcase
        end
    end

    // Bits just switched to edge mode are cleared on the following clock so a
    // stale level value is never mistaken for a captured edge.
    assign edge_arm_d = edge_sel_d & ~edge_sel_q;

    // Edge capture: set wins over a coincident W1C; level bits ignore W1C.
    assign pending_d = ~edge_arm_q &
                       ((edge_sel_q & (rise | (pending_q & ~w1c))) |
                        (~edge_sel_q & s2));

    assign irq_d = |active;

    // Descending scan leaves the lowest active index as the winner.
    always_comb begin
        high_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                high_idx = 4'(i);
            end
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_PENDING:  readdata_d[NUM_SRC-1:0] = pending_q;
            ADDR_MASK:     readdata_d[NUM_SRC-1:0] = mask_q;
            ADDR_EDGE_SEL: readdata_d[NUM_SRC-1:0] = edge_sel_q;
            ADDR_ACTIVE:   readdata_d[NUM_SRC-1:0] = active;
            ADDR_HIGHEST: begin
                readdata_d[HIGHEST_VLD_BIT] = |active;
                readdata_d[3:0]             = high_idx;
            end
            ADDR_RAW:      readdata_d[NUM_SRC-1:0] = s2;
            default:       readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            mask_q     <= '0;
            edge_sel_q <= '0;
            edge_arm_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            edge_sel_q <= edge_sel_d;
            edge_arm_q <= edge_arm_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
